// File: rtl/cla_nibble_seq_pkg.sv
// cla_seq_pkg: shared types and constants for the nibble-serial CLA adder.
// Build option: define SUB_EN to enable subtraction (op = 1 computes a - b).
package cla_seq_pkg;

    // Controller states; the top maps these onto plain localparam codes.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the single time-shared carry-lookahead slice.
    localparam int NIBBLE_W = 4;

    // Number of slice passes needed for a WIDTH-bit operation.
    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/cla_nibble_seq_if.sv
// cla_nibble_seq_if: operand/result handshake bundle for cla_nibble_seq.
// master = operand producer / result consumer, slave = the adder.
interface cla_nibble_seq_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output ovf
    );

endinterface

// File: rtl/cla_nibble_seq_cla.sv
// CLA: purely combinational 4-bit carry-lookahead slice (a + b + c0).
// Every carry is formed directly from generate/propagate terms, so no
// ripple path exists inside the slice.
module CLA
    import cla_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c0,
    output logic [NIBBLE_W-1:0] s,
    output logic                c4
);

    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = c0;
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s  = p ^ c[NIBBLE_W-1:0];
    assign c4 = c[NIBBLE_W];

endmodule

// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq: WIDTH-bit adder that reuses one 4-bit CLA slice for
// NIB = WIDTH/4 cycles, carrying between nibbles through a register.
// Build option: SUB_EN -- when defined, op = 1 computes a + ~b + 1 and
// ignores cin; when undefined, op is ignored and no inversion logic exists.
module cla_nibble_seq
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_nibble_seq_if.slave  bus
);

    localparam int NIB = nib_count(WIDTH);
    localparam int K_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
            $error("cla_nibble_seq: WIDTH must be a non-zero multiple of 4");
        end
    endgenerate

    // Control state
    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [K_W-1:0]   k_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    // Latched operands and result
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    // Slice connections
    logic [NIBBLE_W-1:0] a_nibs [NIB];
    logic [NIBBLE_W-1:0] b_nibs [NIB];
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c4;
    logic [WIDTH-1:0]    sum_run;

    logic             accept;
    logic             last_nib;
    logic             ovf_calc;
    logic [WIDTH-1:0] b_in_eff;
    logic             c_in_eff;

    assign accept   = (state_reg == ST_IDLE) && bus.in_valid && in_ready_reg;
    assign last_nib = (k_reg == K_W'(NIB - 1));

    // Subtraction is folded into the operands at acceptance so the RUN
    // datapath is identical for add and subtract.
`ifdef SUB_EN
    assign b_in_eff = bus.op ? ~bus.b : bus.b;
    assign c_in_eff = bus.op ? 1'b1   : bus.cin;
`else
    logic unused_op;
    assign unused_op = bus.op;
    assign b_in_eff  = bus.b;
    assign c_in_eff  = bus.cin;
`endif

    // Split the latched operands into nibbles and build the merged sum
    // with the current slice output dropped into nibble k.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nibs[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign b_nibs[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign sum_run[gi*NIBBLE_W +: NIBBLE_W] =
                (k_reg == K_W'(gi)) ? slice_s : sum_reg[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    CLA u_cla (
        .a  (a_nibs[k_reg]),
        .b  (b_nibs[k_reg]),
        .c0 (carry_reg),
        .s  (slice_s),
        .c4 (slice_c4)
    );

    // Signed overflow: operands share a sign and the result sign differs.
    // slice_s[3] is the MSB of the result during the final nibble.
    assign ovf_calc = (a_reg[WIDTH-1] ~^ b_reg[WIDTH-1])
                    & (slice_s[NIBBLE_W-1] != a_reg[WIDTH-1]);

    // Next-state selection for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)        state_next = ST_RUN;
            ST_RUN:  if (last_nib)      state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // Control registers; handshake outputs are registered copies of the
    // upcoming state so nothing combinational reaches the ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next == ST_IDLE);
            out_valid_reg <= (state_next == ST_DONE);
        end
    end

    // Datapath: latch operands on acceptance, then one nibble per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_reg     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= b_in_eff;
            carry_reg <= c_in_eff;
            k_reg     <= '0;
        end else if (state_reg == ST_RUN) begin
            sum_reg   <= sum_run;
            carry_reg <= slice_c4;
            k_reg     <= k_reg + K_W'(1);
            if (last_nib) begin
                cout_reg <= slice_c4;
                ovf_reg  <= ovf_calc;
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;

endmodule
